// File: rtl/spi_matrix_unloader.sv
// ============================================================================
// Module      : spi_matrix_unloader
// Description : Streams a header word and then rows*cols result words from a
//               synchronous result memory through the SPI slave tx handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_matrix_unloader #(
   parameter int          MAX_C   = 64,
   parameter int          ADDR_W  = 6,
   parameter logic [7:0]  HDR_TAG = 8'h0C
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [11:0]       rows,
   input  logic [11:0]       cols,
   input  logic              abort,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   output logic [31:0]       tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [23:0] c_max_total = 24'(MAX_C);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_FETCH  = 3'd2,
      S_LOAD   = 3'd3,
      S_SEND   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t      r_state;
   logic [23:0] r_total;
   logic [15:0] r_index;

   logic [23:0] w_total;
   logic        w_last;

   assign w_total = {12'd0, rows} * {12'd0, cols};
   // r_total is at least 1 whenever SEND is reached, so total-1 cannot wrap
   assign w_last  = ({8'd0, r_index} == (r_total - 24'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_total  <= 24'd0;
         r_index  <= 16'd0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         tx_data  <= 32'd0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         rd_en <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            r_state  <= S_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     if (w_total > c_max_total) begin
                        err <= 1'b1;
                     end else begin
                        r_total  <= w_total;
                        r_index  <= 16'd0;
                        busy     <= 1'b1;
                        tx_data  <= {HDR_TAG, rows, cols};
                        tx_valid <= 1'b1;
                        r_state  <= S_HDR;
                     end
                  end
               end
               S_HDR: begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     if (r_total == 24'd0) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FINISH;
                     end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= r_index[ADDR_W-1:0];
                        r_state <= S_FETCH;
                     end
                  end
               end
               S_FETCH: begin
                  r_state <= S_LOAD;
               end
               S_LOAD: begin
                  tx_data  <= rd_data;
                  tx_valid <= 1'b1;
                  r_state  <= S_SEND;
               end
               S_SEND: begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     r_index  <= r_index + 16'd1;
                     if (w_last) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FINISH;
                     end else begin
                        // read for the next word is issued on the same edge as the transfer
                        rd_en   <= 1'b1;
                        rd_addr <= r_index[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_state <= S_FETCH;
                     end
                  end
               end
               S_FINISH: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_matrix_unloader.sv
// ============================================================================
// Module      : tb_spi_matrix_unloader
// Description : Scoreboard bench for spi_matrix_unloader with random data/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_matrix_unloader;

   logic        clk = 1'b0;
   logic        rst, start, abort, tx_ready;
   logic [11:0] rows, cols;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data, tx_data;
   logic        tx_valid, busy, done, err;

   logic [31:0] mem [0:63];

   int n_checks = 0, n_pass = 0;
   logic [31:0] exp_q[$];
   int rd_log[$];
   int n_xfer = 0, n_done = 0, n_err = 0, n_valid_cyc = 0, n_busy_cyc = 0;
   int cyc = 0, last_xfer_cyc = 0;
   int ready_mode = 0, stall_cnt = 0;
   bit prev_hold = 1'b0;
   logic [31:0] prev_data = 32'd0;

   spi_matrix_unloader #(.MAX_C(64), .ADDR_W(6), .HDR_TAG(8'h0C)) dut (
      .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
      .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous result memory, 1-cycle read latency
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall per word
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = ($urandom_range(0, 3) != 0);
         default: begin
            if (!tx_valid) begin
               stall_cnt = 0;
               tx_ready  = 1'b0;
            end else if (stall_cnt < 5) begin
               stall_cnt++;
               tx_ready = 1'b0;
            end else begin
               tx_ready = 1'b1;
            end
         end
      endcase
   end

   // monitor: pops the scoreboard on every accepted word
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", tx_data, prev_data);
         end
         if (tx_valid) n_valid_cyc++;
         if (busy) n_busy_cyc++;
         if (rd_en) rd_log.push_back(int'(rd_addr));
         if (err) n_err++;
         if (done) begin
            n_done++;
            check("done_gap", cyc - last_xfer_cyc, 32'd1);
            check("done_err_excl", {31'd0, err}, 32'd0);
            check("busy_at_done", {31'd0, busy}, 32'd0);
         end
         prev_hold = tx_valid && !tx_ready && !abort;
         prev_data = tx_data;
         if (tx_valid && tx_ready && !abort) begin
            n_xfer++;
            last_xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %0h expected none", tx_data);
            end else begin
               check("word", tx_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      check("rst_rd_en", {31'd0, rd_en}, 32'd0);
      check("rst_rd_addr", {26'd0, rd_addr}, 32'd0);
      check("rst_tx_data", tx_data, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
   endtask

   // reference: header {tag,rows,cols} followed by mem[0..npush-1]
   task automatic launch(input int r, input int c, input int npush);
      logic [11:0] r12, c12;
      r12 = 12'(r);
      c12 = 12'(c);
      exp_q.push_back({8'h0C, r12, c12});
      for (int i = 0; i < npush; i++) exp_q.push_back(mem[i]);
      rows  = r12;
      cols  = c12;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (n_done != d0) begin
            ok = 1'b1;
            break;
         end
      end
      check("job_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_xfer(input int target, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (n_xfer >= target && (target >= 0)) begin
            ok = 1'b1;
            break;
         end
      end
      check("xfer_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic job_checks(input int d0, input int nwords);
      tick();
      tick();
      check("queue_empty", exp_q.size(), 32'd0);
      check("done_count", n_done - d0, 32'd1);
      check("rd_count", rd_log.size(), nwords);
      for (int i = 0; i < rd_log.size() && i < nwords; i++) check("rd_addr_seq", rd_log[i], i);
      check("busy_after", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_job(input int r, input int c, input int mode);
      int d0;
      ready_mode = mode;
      rd_log.delete();
      d0 = n_done;
      launch(r, c, r * c);
      wait_done(d0, 3000);
      job_checks(d0, r * c);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, e0, v0, b0, x0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; rows = 12'd0; cols = 12'd0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      repeat (3) tick();
      check_reset_vals();
      rst = 1'b0;
      tick();

      // 2x2 with known data, then the same job under stalls
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      run_job(2, 2, 0);
      run_job(2, 2, 2);

      // full-capacity job
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      run_job(8, 8, 1);
      if (rd_log.size() == 64) check("last_addr", rd_log[63], 32'd63);
      else check("last_addr_count", rd_log.size(), 32'd64);

      // oversize request rejected
      e0 = n_err; v0 = n_valid_cyc; b0 = n_busy_cyc;
      rows = 12'd5; cols = 12'd13; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("err_count", n_err - e0, 32'd1);
      check("err_no_valid", n_valid_cyc - v0, 32'd0);
      check("err_no_busy", n_busy_cyc - b0, 32'd0);

      // zero-size job: header only
      run_job(0, 7, 1);

      // abort after second data word of a 3x3 job
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      ready_mode = 0;
      rd_log.delete();
      d0 = n_done; x0 = n_xfer;
      launch(3, 3, 2);
      wait_xfer(x0 + 3, 200);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid", {31'd0, tx_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_rd_en", {31'd0, rd_en}, 32'd0);
      repeat (4) tick();
      check("abort_no_done", n_done - d0, 32'd0);
      check("abort_queue", exp_q.size(), 32'd0);
      exp_q.delete();
      run_job(1, 1, 0);

      // reset while a data word is stalled in SEND
      ready_mode = 2;
      x0 = n_xfer;
      launch(2, 2, 4);
      begin
         bit ok;
         ok = 1'b0;
         for (int i = 0; i < 200; i++) begin
            tick();
            if (n_xfer >= x0 + 1 && tx_valid) begin
               ok = 1'b1;
               break;
            end
         end
         check("send_timeout", {31'd0, ok}, 32'd1);
      end
      rst = 1'b1;
      tick();
      check_reset_vals();
      rst = 1'b0;
      exp_q.delete();
      tick();

      // redundant start mid-transfer is ignored
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      ready_mode = 1;
      rd_log.delete();
      d0 = n_done; e0 = n_err; x0 = n_xfer;
      launch(2, 2, 4);
      wait_xfer(x0 + 2, 200);
      rows = 12'd3; cols = 12'd3; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(d0, 500);
      job_checks(d0, 4);
      check("redundant_no_err", n_err - e0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
